// File: rtl/cosine_loss_vec_streamer.sv
// Interleaves a prediction and a target buffer into one valid/ready word stream for the cosine-loss operator.
// Optional trailing XOR checksum word: define COSLOSS_TX_CHECKSUM_EN.
module cosine_loss_vec_streamer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   vec_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [31:0]       output_data,
    output logic              last_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic              sel;
    logic [31:0]       pred_mem [DEPTH];
    logic [31:0]       tgt_mem  [DEPTH];
    logic [31:0]       data_word;
    logic              len_ok;
    logic              fire;
    logic              last_data;

    assign len_ok    = (vec_len != '0) && (vec_len <= MAX_LEN);
    assign data_word = sel ? tgt_mem[idx] : pred_mem[idx];
    assign last_data = sel && ({1'b0, idx} == (len - 1'b1));
    assign busy      = (state == SEND);
    assign valid_out = (state == SEND);
    assign done      = (state == DONE_ST);
    assign fire      = valid_out && ready_in;

    // Buffers are frozen while a frame is on the wire so the stream is self-consistent.
    always_ff @(posedge clk) begin
        if (wr_en && state != SEND) begin
            if (wr_sel)
                tgt_mem[wr_addr] <= wr_data;
            else
                pred_mem[wr_addr] <= wr_data;
        end
    end

`ifdef COSLOSS_TX_CHECKSUM_EN
    logic        ck_phase;
    logic [31:0] csum;

    assign output_data = (state == SEND) ? (ck_phase ? csum : data_word) : 32'd0;
    assign last_out    = (state == SEND) && ck_phase;
`else
    assign output_data = (state == SEND) ? data_word : 32'd0;
    assign last_out    = (state == SEND) && last_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            len   <= '0;
            sel   <= 1'b0;
            err   <= 1'b0;
`ifdef COSLOSS_TX_CHECKSUM_EN
            ck_phase <= 1'b0;
            csum     <= 32'd0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len   <= vec_len;
                            idx   <= '0;
                            sel   <= 1'b0;
                            state <= SEND;
`ifdef COSLOSS_TX_CHECKSUM_EN
                            ck_phase <= 1'b0;
                            csum     <= 32'd0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (fire) begin
`ifdef COSLOSS_TX_CHECKSUM_EN
                        if (ck_phase) begin
                            state <= DONE_ST;
                        end else begin
                            csum <= csum ^ data_word;
                            if (last_data)
                                ck_phase <= 1'b1;
                            if (sel) begin
                                sel <= 1'b0;
                                idx <= idx + 1'b1;
                            end else begin
                                sel <= 1'b1;
                            end
                        end
`else
                        if (last_data)
                            state <= DONE_ST;
                        if (sel) begin
                            sel <= 1'b0;
                            idx <= idx + 1'b1;
                        end else begin
                            sel <= 1'b1;
                        end
`endif
                    end
                end
                DONE_ST: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_loss_vec_streamer.sv
// Directed bench for cosine_loss_vec_streamer; inputs driven and outputs sampled on the falling edge.
// Build with COSLOSS_TX_CHECKSUM_EN defined to cover the trailing checksum word.
module tb_cosine_loss_vec_streamer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [6:0]  vec_len;
    logic        busy;
    logic        done;
    logic        err;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] output_data;
    logic        last_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pred [64];
    logic [31:0] m_tgt  [64];
    logic [31:0] exp_words [130];

    cosine_loss_vec_streamer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .err(err),
        .valid_out(valid_out), .ready_in(ready_in),
        .output_data(output_data), .last_out(last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One buffer write; the reference copy only tracks writes that should land.
    task automatic applyStimulus(input logic sel, input logic [5:0] addr, input logic [31:0] data);
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) m_tgt[addr] = data;
        else     m_pred[addr] = data;
    endtask

    task automatic runFrame(input int n, input bit backpressure, input bit inject);
        int nw;
        int w;
        int cyc;
        logic rdy;
        logic [31:0] ck;
        ck = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_words[2*i]   = m_pred[i];
            exp_words[2*i+1] = m_tgt[i];
            ck = ck ^ m_pred[i] ^ m_tgt[i];
        end
        nw = 2 * n;
`ifdef COSLOSS_TX_CHECKSUM_EN
        exp_words[nw] = ck;
        nw = nw + 1;
`endif
        start    = 1'b1;
        vec_len  = 7'(n);
        ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w   = 0;
        cyc = 0;
        while (w < nw && cyc < 400) begin
            rdy = backpressure ? ((cyc % 3) == 0) : 1'b1;
            ready_in = rdy;
            if (inject && cyc == 1) begin
                wr_sel  = 1'b0;
                wr_addr = 6'd1;
                wr_data = 32'd99;
                wr_en   = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            checkOutput("frame_valid", 32'(valid_out), 32'd1);
            checkOutput("frame_busy", 32'(busy), 32'd1);
            checkOutput("frame_data", output_data, exp_words[w]);
            checkOutput("frame_last", 32'(last_out), 32'(w == nw - 1));
            @(negedge clk);
            if (rdy) w++;
            cyc++;
        end
        wr_en    = 1'b0;
        ready_in = 1'b0;
        checkOutput("frame_words", 32'(w), 32'(nw));
        checkOutput("frame_done", 32'(done), 32'd1);
        checkOutput("frame_done_busy", 32'(busy), 32'd0);
        checkOutput("frame_done_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        checkOutput("post_done", 32'(done), 32'd0);
        checkOutput("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        vec_len  = '0;
        ready_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_last", 32'(last_out), 32'd0);
        checkOutput("rst_data", output_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 6'd0, 32'd1);
        applyStimulus(1'b0, 6'd1, 32'd2);
        applyStimulus(1'b0, 6'd2, 32'd3);
        applyStimulus(1'b1, 6'd0, 32'd10);
        applyStimulus(1'b1, 6'd1, 32'd20);
        applyStimulus(1'b1, 6'd2, 32'd30);

        $display("[TB] basic frame");
        runFrame(3, 1'b0, 1'b0);

        $display("[TB] backpressure frame");
        runFrame(3, 1'b1, 1'b0);

        $display("[TB] bad lengths");
        start   = 1'b1;
        vec_len = 7'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0_err", 32'(err), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        checkOutput("len0_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        checkOutput("len0_err_clear", 32'(err), 32'd0);
        checkOutput("len0_valid2", 32'(valid_out), 32'd0);
        start   = 1'b1;
        vec_len = 7'd65;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len65_err", 32'(err), 32'd1);
        checkOutput("len65_busy", 32'(busy), 32'd0);
        checkOutput("len65_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        checkOutput("len65_err_clear", 32'(err), 32'd0);
        checkOutput("len65_valid2", 32'(valid_out), 32'd0);

        $display("[TB] write during frame is dropped");
        runFrame(3, 1'b0, 1'b1);
        runFrame(3, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 6'd3, 32'd4);
        applyStimulus(1'b1, 6'd3, 32'd40);
        start    = 1'b1;
        vec_len  = 7'd4;
        ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mid_word0", output_data, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_word3", output_data, 32'd20);
        checkOutput("mid_valid_pre", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(valid_out), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("mid_rst_done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        ready_in = 1'b0;
        @(negedge clk);
        runFrame(1, 1'b0, 1'b0);

`ifdef COSLOSS_TX_CHECKSUM_EN
        $display("[TB] checksum frame");
        applyStimulus(1'b0, 6'd0, 32'h0F);
        applyStimulus(1'b1, 6'd0, 32'hF0);
        runFrame(1, 1'b0, 1'b0);
        checkOutput("csum_value", exp_words[2], 32'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
